hyperbus_cfg_seq: RTL and testbench
===================================

Name: hyperbus_cfg_seq

Overview:
Boot-time configuration sequencer for the HyperBus controller's register interface.
- After reset it waits a start-up delay, then writes a parameter-defined table of (address, data) pairs over reg bus.
- Once the table completes, it hands the reg port to the external requester.
- It sits between the system reg crossbar and the HyperBus controller's reg_req/reg_rsp port, in the controller's system clock domain.

Parameters:
- RegAddrWidth, 32: reg bus address width.
- RegDataWidth, 32: reg bus data width.
- reg_req_t, logic: reg bus request struct (addr, write, wdata, wstrb, valid).
- reg_rsp_t, logic: reg bus response struct (rdata, error, ready).
- NumEntries, 4: config table depth, must be >= 1.
- CfgAddr, '0: NumEntries x RegAddrWidth table of register addresses; entry 0 is issued first.
- CfgData, '0: NumEntries x RegDataWidth table of write data.
- StartDelay, 60000: cycles to wait after reset before the first write; 0 means no wait.
- TimeoutCycles, 1024: maximum cycles a transaction may wait for ready; 0 disables the timeout.

Ports:
- clk_i, in, 1: system clock.
- rst_i, in, 1: asynchronous active-high reset.
- restart_i, in, 1: pulse; replays the table.
- ext_reg_req_i, in, reg_req_t: external requester.
- ext_reg_rsp_o, out, reg_rsp_t: response to the external requester.
- reg_req_o, out, reg_req_t: request to the HyperBus controller.
- reg_rsp_i, in, reg_rsp_t: response from the HyperBus controller.
- busy_o, out, 1: sequence pending or running.
- done_o, out, 1: table written without error; passthrough active.
- error_o, out, 1: sequence aborted.
- err_idx_o, out, $clog2(NumEntries) bits (minimum 1): index of the failing entry.

Behaviour:
- States: WAIT, WRITE, (READ), DONE, ERROR. Reset state is WAIT.
- Reset values: idx=0, counter=0, reg_req_o.valid=0, busy_o=1, done_o=0, error_o=0, err_idx_o=0.
- WAIT
  - Counter increments each cycle; at count==StartDelay-1, go to WRITE.
  - StartDelay=0: go to WRITE on the first cycle after reset.
- WRITE
  - Drive reg_req_o = {addr=CfgAddr[idx], wdata=CfgData[idx], write=1, wstrb=all ones, valid=1}.
  - addr, wdata, write and wstrb stay stable while valid=1 and ready=0.
  - Handshake cycle (valid & ready):
    - reg_rsp_i.error=1: go to ERROR, err_idx_o=idx.
    - Otherwise, if idx==NumEntries-1, go to DONE.
    - Otherwise idx++ and the next entry is presented on the following cycle. There is one idle cycle between transactions; valid drops for that cycle.
- Timeout
  - The counter restarts at 0 on entry to each transaction.
  - If the counter reaches TimeoutCycles-1 with no ready: go to ERROR, err_idx_o=idx, valid drops.
  - Controller-side abandonment is accepted and documented behaviour.
- DONE
  - Combinational passthrough: reg_req_o=ext_reg_req_i, ext_reg_rsp_o=reg_rsp_i.
  - busy_o=0, done_o=1.
- Not DONE and not ERROR
  - ext_reg_rsp_o.ready=0, so external requests stall.
  - reg_req_o is driven only by the sequencer.
- ERROR
  - ext_reg_rsp_o = {ready=ext valid, error=1, rdata=0}; each external request completes in one cycle with error.
  - reg_req_o.valid=0, error_o=1, busy_o=0.
- restart_i
  - Honoured only in DONE or ERROR; ignored in WAIT, WRITE and READ.
  - ERROR, or DONE with ext valid=0: next state WRITE, idx=0, error_o=0, done_o=0, no StartDelay.
  - DONE with an external transaction in flight (ext valid=1, ready=0): restart is latched as pending and taken the cycle after that handshake completes, so passthrough is never cut mid-transaction.
- Reset mid-sequence: all state returns to reset values and the sequence restarts with the full StartDelay.

Optional Feature:
HYPERBUS_CFG_SEQ_READBACK_EN
- Defined:
  - After each successful write, enter READ: issue write=0 to the same address.
  - On handshake, if rdata != CfgData[idx] or error=1, go to ERROR with err_idx_o=idx.
  - Otherwise advance as in WRITE.
  - The READ transaction has its own timeout.
- Undefined: the READ state does not exist; WRITE advances directly.

Decomposition:
- Package hyperbus_cfg_seq_pkg:
  - state enum cfg_seq_state_e (WAIT, WRITE, READ, DONE, ERROR).
  - localparam CntWidth function: max of the StartDelay and TimeoutCycles widths.
- No sub-module. A single counter is shared between the start-up delay and the per-transaction timeout.

Test Plan:
- StartDelay=10, NumEntries=3, controller ready=1:
  - First valid appears at cycle 10 after reset deassertion.
  - Writes go to addr 0x0, 0x4, 0x8 with data 0xA, 0xB, 0xC.
  - done_o rises after the third handshake.
- Controller ready delayed 5 cycles per transaction:
  - addr/wdata stay stable while stalled.
  - External request during the sequence sees ready=0 until done_o=1, then completes via passthrough.
- reg_rsp_i.error=1 on entry 1:
  - error_o=1, err_idx_o=1, no write to entry 2.
  - External read returns error=1, rdata=0 in one cycle.
- TimeoutCycles=8, controller never ready: ERROR after 8 cycles with err_idx_o=0 and valid dropped.
- restart_i in DONE while an external write is stalled 3 cycles:
  - Replay begins the cycle after the external handshake.
  - idx=0 is written again.
- READBACK_EN, controller returns 0xB' for entry 1: error_o=1, err_idx_o=1.

Source files
------------

// File: rtl/hyperbus_cfg_seq_pkg.sv
// Shared types and helpers for the HyperBus boot-time configuration sequencer.
package hyperbus_cfg_seq_pkg;

    typedef enum logic [2:0] {
        WAIT,
        WRITE,
        READ,
        DONE,
        ERROR
    } cfg_seq_state_e;

    // Default 32-bit reg bus structs; wider or narrower buses pass their own types in.
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } cfg_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } cfg_reg_rsp_t;

    // The counter only ever has to reach StartDelay-1 or TimeoutCycles-1.
    function automatic int unsigned cnt_width(input int unsigned start_delay,
                                              input int unsigned timeout_cycles);
        int unsigned w_delay;
        int unsigned w_tmo;
        w_delay = (start_delay > 1) ? $clog2(start_delay) : 1;
        w_tmo   = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
        return (w_delay > w_tmo) ? w_delay : w_tmo;
    endfunction

endpackage

// File: rtl/hyperbus_cfg_seq.sv
// Boot-time register-table writer for the HyperBus controller; hands the reg port to the
// external requester once done. Define HYPERBUS_CFG_SEQ_READBACK_EN to verify each write by reading it back.
module hyperbus_cfg_seq
    import hyperbus_cfg_seq_pkg::*;
#(
    parameter int unsigned RegAddrWidth  = 32,
    parameter int unsigned RegDataWidth  = 32,
    parameter type         reg_req_t     = cfg_reg_req_t,
    parameter type         reg_rsp_t     = cfg_reg_rsp_t,
    parameter int unsigned NumEntries    = 4,
    parameter logic [NumEntries-1:0][RegAddrWidth-1:0] CfgAddr = '0,
    parameter logic [NumEntries-1:0][RegDataWidth-1:0] CfgData = '0,
    parameter int unsigned StartDelay    = 60000,
    parameter int unsigned TimeoutCycles = 1024,
    localparam int unsigned IdxWidth     = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                restart_i,
    input  reg_req_t            ext_reg_req_i,
    output reg_rsp_t            ext_reg_rsp_o,
    output reg_req_t            reg_req_o,
    input  reg_rsp_t            reg_rsp_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o,
    output logic [IdxWidth-1:0] err_idx_o
);

    localparam int unsigned CntWidth = cnt_width(StartDelay, TimeoutCycles);
    localparam logic [CntWidth-1:0] DelayLast =
        (StartDelay == 0) ? '0 : CntWidth'(StartDelay - 1);
    localparam logic [CntWidth-1:0] TimeoutLast =
        (TimeoutCycles == 0) ? '0 : CntWidth'(TimeoutCycles - 1);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumEntries - 1);

    cfg_seq_state_e      state_q, state_d;
    logic [IdxWidth-1:0] idx_q, idx_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [IdxWidth-1:0] err_idx_q, err_idx_d;
    logic                gap_q, gap_d;
    logic                pend_q, pend_d;
    logic                xfer_err;

`ifdef HYPERBUS_CFG_SEQ_READBACK_EN
    assign xfer_err = reg_rsp_i.error
                    | ((state_q == READ) && (reg_rsp_i.rdata != CfgData[idx_q]));
`else
    assign xfer_err = reg_rsp_i.error;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= WAIT;
            idx_q     <= '0;
            cnt_q     <= '0;
            err_idx_q <= '0;
            gap_q     <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            err_idx_q <= err_idx_d;
            gap_q     <= gap_d;
            pend_q    <= pend_d;
        end
    end

    // One counter serves both the start-up delay and the per-transaction timeout.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        err_idx_d = err_idx_q;
        gap_d     = 1'b0;
        pend_d    = pend_q;
        unique case (state_q)
            WAIT: begin
                if (StartDelay == 0 || cnt_q == DelayLast) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE, READ: begin
                if (gap_q) begin
                    cnt_d = '0;
                end else if (reg_rsp_i.ready) begin
                    cnt_d = '0;
                    if (xfer_err) begin
                        state_d   = ERROR;
                        err_idx_d = idx_q;
                    end
`ifdef HYPERBUS_CFG_SEQ_READBACK_EN
                    else if (state_q == WRITE) begin
                        state_d = READ;
                        gap_d   = 1'b1;
                    end
`endif
                    else if (idx_q == LastIdx) begin
                        state_d = DONE;
                    end else begin
                        state_d = WRITE;
                        idx_d   = idx_q + 1'b1;
                        gap_d   = 1'b1;
                    end
                end else if (TimeoutCycles != 0 && cnt_q == TimeoutLast) begin
                    state_d   = ERROR;
                    err_idx_d = idx_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Never cut a passthrough transaction: wait for its handshake first.
                if ((restart_i || pend_q) && (!ext_reg_req_i.valid || reg_rsp_i.ready)) begin
                    state_d = WRITE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end else if (restart_i) begin
                    pend_d = 1'b1;
                end
            end
            ERROR: begin
                if (restart_i) begin
                    state_d = WRITE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = WAIT;
        endcase
    end

    always_comb begin
        reg_req_o     = '0;
        ext_reg_rsp_o = '0;
        unique case (state_q)
            WRITE, READ: begin
                reg_req_o.addr  = CfgAddr[idx_q];
                reg_req_o.wdata = CfgData[idx_q];
                reg_req_o.write = (state_q == WRITE);
                reg_req_o.wstrb = '1;
                reg_req_o.valid = !gap_q;
            end
            DONE: begin
                reg_req_o     = ext_reg_req_i;
                ext_reg_rsp_o = reg_rsp_i;
            end
            ERROR: begin
                ext_reg_rsp_o.ready = ext_reg_req_i.valid;
                ext_reg_rsp_o.error = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy_o    = (state_q != DONE) && (state_q != ERROR);
    assign done_o    = (state_q == DONE);
    assign error_o   = (state_q == ERROR);
    assign err_idx_o = err_idx_q;

endmodule

// File: tb/tb_hyperbus_cfg_seq.sv
// Scoreboard bench for hyperbus_cfg_seq: expected reg-bus and external transactions are queued by the
// stimulus and popped by independent monitors on the falling clock edge.
module tb_hyperbus_cfg_seq;

    typedef hyperbus_cfg_seq_pkg::cfg_reg_req_t req_t;
    typedef hyperbus_cfg_seq_pkg::cfg_reg_rsp_t rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } reg_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        error;
    } ext_exp_t;

`ifdef HYPERBUS_CFG_SEQ_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_i;
    logic       restart_i;
    req_t       ext_req;
    rsp_t       ext_rsp;
    req_t       req;
    rsp_t       rsp;
    logic       busy_o, done_o, error_o;
    logic [1:0] err_idx_o;

    hyperbus_cfg_seq #(
        .NumEntries   (3),
        .CfgAddr      ({32'h8, 32'h4, 32'h0}),
        .CfgData      ({32'hC, 32'hB, 32'hA}),
        .StartDelay   (10),
        .TimeoutCycles(8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .restart_i    (restart_i),
        .ext_reg_req_i(ext_req),
        .ext_reg_rsp_o(ext_rsp),
        .reg_req_o    (req),
        .reg_rsp_i    (rsp),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .err_idx_o    (err_idx_o)
    );

    always #5 clk = ~clk;

    int          nchecks = 0;
    int          nerrors = 0;
    reg_exp_t    reg_q[$];
    ext_exp_t    ext_q[$];
    logic [31:0] exp_addr[3];
    logic [31:0] exp_data[3];
    logic [31:0] mem[32];
    int          ready_delay = 0;
    bit          never_ready = 1'b0;
    bit          err_en      = 1'b0;
    bit          corrupt_en  = 1'b0;
    logic [31:0] err_addr    = 32'h0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push_entry(input int i, input bit with_read);
        reg_q.push_back('{exp_addr[i], 1'b1, exp_data[i]});
        if (with_read) reg_q.push_back('{exp_addr[i], 1'b0, 32'h0});
    endfunction

    function automatic void push_table();
        for (int i = 0; i < 3; i++) push_entry(i, RB);
    endfunction

    // Controller model: stalls ready_delay cycles per transaction, then accepts.
    initial begin
        int ccnt;
        ccnt = 0;
        rsp  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rsp.ready) ccnt = 0;
            rsp = '0;
            if (req.valid && !never_ready) begin
                if (ccnt >= ready_delay) begin
                    rsp.ready = 1'b1;
                    rsp.error = err_en && (req.addr == err_addr);
                    if (req.write) mem[req.addr[6:2]] = req.wdata;
                    else if (corrupt_en && req.addr == 32'h4) rsp.rdata = 32'hB0;
                    else rsp.rdata = mem[req.addr[6:2]];
                end else begin
                    ccnt++;
                end
            end else if (!req.valid) begin
                ccnt = 0;
            end
        end
    end

    // Reg-side monitor: handshakes against the scoreboard, request stability while stalled.
    initial begin
        logic        prev_v, prev_hs;
        logic [31:0] prev_a, prev_d;
        reg_exp_t    e;
        prev_v = 1'b0; prev_hs = 1'b0; prev_a = '0; prev_d = '0;
        forever begin
            @(negedge clk);
            if (prev_v && !prev_hs && req.valid) begin
                chk("stall_addr_stable", req.addr, prev_a);
                chk("stall_wdata_stable", req.wdata, prev_d);
            end
            if (req.valid && rsp.ready) begin
                if (reg_q.size() == 0) begin
                    nchecks++;
                    nerrors++;
                    $display("FAIL reg_unexpected: addr 0x%0h write %0b, expected no transaction", req.addr, req.write);
                end else begin
                    e = reg_q.pop_front();
                    chk("reg_addr", req.addr, e.addr);
                    chk("reg_write", req.write, e.write);
                    if (e.write) chk("reg_wdata", req.wdata, e.wdata);
                end
            end
            prev_v  = req.valid;
            prev_hs = req.valid && rsp.ready;
            prev_a  = req.addr;
            prev_d  = req.wdata;
        end
    end

    // External-side monitor.
    initial begin
        ext_exp_t e;
        forever begin
            @(negedge clk);
            if (ext_req.valid && ext_rsp.ready) begin
                chk("ext_ready_only_done_or_error", done_o | error_o, 1'b1);
                if (ext_q.size() == 0) begin
                    nchecks++;
                    nerrors++;
                    $display("FAIL ext_unexpected: addr 0x%0h, expected no response", ext_req.addr);
                end else begin
                    e = ext_q.pop_front();
                    chk("ext_rdata", ext_rsp.rdata, e.rdata);
                    chk("ext_error", ext_rsp.error, e.error);
                end
            end
        end
    end

    task automatic ext_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input int max_wait, output int waited);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        ext_req.addr  = a;
        ext_req.write = w;
        ext_req.wdata = d;
        ext_req.wstrb = '1;
        ext_req.valid = 1'b1;
        waited = 0;
        while (!got && waited <= max_wait) begin
            @(negedge clk);
            if (ext_rsp.ready) got = 1'b1;
            else waited++;
        end
        chk("ext_handshake_seen", got, 1'b1);
        @(posedge clk);
        #1;
        ext_req = '0;
    endtask

    task automatic wait_flag(input bit want_err, input string name, input int maxc);
        int n;
        n = 0;
        while ((want_err ? error_o : done_o) !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(name, want_err ? error_o : done_o, 1'b1);
    endtask

    task automatic pulse_restart();
        @(posedge clk);
        #1 restart_i = 1'b1;
        @(posedge clk);
        #1 restart_i = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n;
        exp_addr = '{32'h0, 32'h4, 32'h8};
        exp_data = '{32'hA, 32'hB, 32'hC};
        for (int i = 0; i < 32; i++) mem[i] = '0;
        rst_i     = 1'b1;
        restart_i = 1'b0;
        ext_req   = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_valid", req.valid, 1'b0);
        chk("rst_busy", busy_o, 1'b1);
        chk("rst_done", done_o, 1'b0);
        chk("rst_error", error_o, 1'b0);
        chk("rst_err_idx", err_idx_o, 2'd0);

        // Start-up delay and plain table write
        push_table();
        @(posedge clk);
        #1 rst_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("delay_no_valid_cycle9", req.valid, 1'b0);
        @(negedge clk);
        chk("first_valid_cycle10", req.valid, 1'b1);
        chk("first_addr", req.addr, 32'h0);
        chk("first_wstrb", req.wstrb, 4'hF);
        wait_flag(1'b0, "done_after_table", 200);
        chk("all_hs_before_done", reg_q.size(), 0);
        chk("done_busy", busy_o, 1'b0);

        // Stalled controller, external write waits for passthrough
        ready_delay = 5;
        push_table();
        reg_q.push_back('{32'h20, 1'b1, 32'h55});
        ext_q.push_back('{32'h0, 1'b0});
        pulse_restart();
        chk("restart_clears_done", done_o, 1'b0);
        fork
            ext_xfer(32'h20, 1'b1, 32'h55, 400, w);
            wait_flag(1'b0, "done_after_stalled_table", 400);
        join
        chk("ext_stalled_during_seq", w > 10, 1'b1);
        reg_q.push_back('{32'h20, 1'b0, 32'h0});
        ext_q.push_back('{32'h55, 1'b0});
        ext_xfer(32'h20, 1'b0, 32'h0, 50, w);

        // Error response on entry 1
        ready_delay = 0;
        err_en      = 1'b1;
        err_addr    = 32'h4;
        push_entry(0, RB);
        reg_q.push_back('{32'h4, 1'b1, 32'hB});
        pulse_restart();
        wait_flag(1'b1, "error_on_entry1", 200);
        chk("err_idx_entry1", err_idx_o, 2'd1);
        chk("err_busy", busy_o, 1'b0);
        chk("err_done", done_o, 1'b0);
        chk("err_valid_dropped", req.valid, 1'b0);
        repeat (5) @(negedge clk);
        chk("no_write_entry2", reg_q.size(), 0);
        ext_q.push_back('{32'h0, 1'b1});
        ext_xfer(32'h0, 1'b0, 32'h0, 10, w);
        chk("err_ext_one_cycle", w, 0);

        // Timeout with controller never ready
        err_en      = 1'b0;
        never_ready = 1'b1;
        pulse_restart();
        n = 0;
        while (!error_o && n < 40) begin
            @(negedge clk);
            if (req.valid) n++;
        end
        chk("timeout_valid_cycles", n, 8);
        chk("timeout_error", error_o, 1'b1);
        chk("timeout_err_idx", err_idx_o, 2'd0);
        chk("timeout_valid_dropped", req.valid, 1'b0);

        // Restart from DONE while an external write is stalled
        never_ready = 1'b0;
        push_table();
        pulse_restart();
        wait_flag(1'b0, "done_before_pending", 200);
        ready_delay = 3;
        reg_q.push_back('{32'h24, 1'b1, 32'h77});
        ext_q.push_back('{32'h0, 1'b0});
        push_table();
        @(posedge clk);
        #1;
        ext_req.addr  = 32'h24;
        ext_req.write = 1'b1;
        ext_req.wdata = 32'h77;
        ext_req.wstrb = '1;
        ext_req.valid = 1'b1;
        @(posedge clk);
        #1 restart_i = 1'b1;
        @(posedge clk);
        #1 restart_i = 1'b0;
        @(negedge clk);
        chk("pending_keeps_passthrough", done_o, 1'b1);
        n = 0;
        while (!ext_rsp.ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pending_ext_handshake", ext_rsp.ready, 1'b1);
        @(posedge clk);
        #1 ext_req = '0;
        @(negedge clk);
        chk("replay_next_cycle_valid", req.valid, 1'b1);
        chk("replay_addr_idx0", req.addr, 32'h0);
        chk("replay_busy", busy_o, 1'b1);
        wait_flag(1'b0, "done_after_replay", 300);

`ifdef HYPERBUS_CFG_SEQ_READBACK_EN
        // Readback mismatch on entry 1
        ready_delay = 0;
        corrupt_en  = 1'b1;
        push_entry(0, 1'b1);
        push_entry(1, 1'b1);
        pulse_restart();
        wait_flag(1'b1, "readback_mismatch_error", 200);
        chk("readback_err_idx", err_idx_o, 2'd1);
`endif

        repeat (5) @(negedge clk);
        chk("reg_queue_empty", reg_q.size(), 0);
        chk("ext_queue_empty", ext_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
